// File: rtl/rs_chien_seq.sv
// rs_chien_seq -- sequential, backpressured Chien search for the RS decoder.
//
// Accepts one error-locator polynomial per codeword. It sweeps the N_LEN
// symbol positions ROOTS_PER_CYCLE at a time, streams one error-position
// bitmap per beat, and then emits a one-cycle summary.
//
// Optional feature: define RS_CHIEN_SEQ_EARLY_TERM_EN to stop the sweep on
// the beat where the accumulated root count reaches the locator degree.
//
// The GF(2^8) arithmetic package gf_pkg lives in this file so that the block
// is self-contained.

package gf_pkg;
  localparam int SYMB_WIDTH = 8;
  localparam int T_LEN      = 8;
  localparam int GF_ORDER   = (1 << SYMB_WIDTH) - 1;
  // Primitive polynomial x^8 + x^4 + x^3 + x^2 + 1; alpha = 2.
  localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

  // Multiply by alpha: shift left and reduce by the primitive polynomial.
  function automatic logic [SYMB_WIDTH-1:0] gf_xtime(input logic [SYMB_WIDTH-1:0] a);
    logic [SYMB_WIDTH-1:0] r;
    r = {a[SYMB_WIDTH-2:0], 1'b0};
    if (a[SYMB_WIDTH-1]) begin
      r = r ^ PRIM_POLY[SYMB_WIDTH-1:0];
    end else begin
      r = r;
    end
    return r;
  endfunction

  // General GF multiply, shift-and-add.
  function automatic logic [SYMB_WIDTH-1:0] gf_mul(input logic [SYMB_WIDTH-1:0] a,
                                                   input logic [SYMB_WIDTH-1:0] b);
    logic [SYMB_WIDTH-1:0] p;
    logic [SYMB_WIDTH-1:0] aa;
    p  = {SYMB_WIDTH{1'b0}};
    aa = a;
    for (int k = 0; k < SYMB_WIDTH; k++) begin
      if (b[k]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // alpha^e. This is used only to build constants at elaboration time.
  function automatic logic [SYMB_WIDTH-1:0] gf_alpha_pow(input int e);
    logic [SYMB_WIDTH-1:0] r;
    r = {{(SYMB_WIDTH-1){1'b0}}, 1'b1};
    for (int k = 0; k < GF_ORDER; k++) begin
      if (k < (e % GF_ORDER)) begin
        r = gf_xtime(r);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Evaluate Lambda(x) with Horner's rule. Coefficient j sits at [j*SYMB_WIDTH +: SYMB_WIDTH].
  function automatic logic [SYMB_WIDTH-1:0] gf_eval(input logic [(T_LEN+1)*SYMB_WIDTH-1:0] lam,
                                                    input logic [SYMB_WIDTH-1:0] x);
    logic [SYMB_WIDTH-1:0] acc;
    acc = lam[T_LEN*SYMB_WIDTH +: SYMB_WIDTH];
    for (int j = T_LEN - 1; j >= 0; j--) begin
      acc = gf_mul(acc, x) ^ lam[j*SYMB_WIDTH +: SYMB_WIDTH];
    end
    return acc;
  endfunction
endpackage

module rs_chien_seq
  import gf_pkg::*;
#(
  parameter int N_LEN           = 255,
  parameter int ROOTS_PER_CYCLE = 8
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   loc_valid,
  output logic                                   loc_ready,
  input  logic [(gf_pkg::T_LEN+1)*gf_pkg::SYMB_WIDTH-1:0] error_locator,
  input  logic [$clog2(gf_pkg::T_LEN+1)-1:0]     loc_degree,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ROOTS_PER_CYCLE-1:0]             error_bit_pos,
  output logic                                   out_first,
  output logic                                   out_last,
  output logic                                   sum_valid,
  output logic [$clog2(N_LEN+1)-1:0]             err_cnt,
  output logic                                   uncorrectable
);

  localparam int SW         = SYMB_WIDTH;
  localparam int RPC        = ROOTS_PER_CYCLE;
  localparam int LAM_W      = (T_LEN + 1) * SW;
  localparam int BEATS      = (N_LEN + RPC - 1) / RPC;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W      = $clog2(N_LEN + 1);
  localparam int DEG_W      = $clog2(T_LEN + 1);
  // Number of lanes in the final beat that map to real positions.
  localparam int LAST_LANES = N_LEN - (BEATS - 1) * RPC;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  // Per-beat root step: alpha^(-RPC).
  localparam logic [SW-1:0] STEP_ROOT = gf_alpha_pow((GF_ORDER - (RPC % GF_ORDER)) % GF_ORDER);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_SUMMARY = 2'd2
  } state_e;

  state_e             state_q;
  logic               loc_ready_q;
  logic [LAM_W-1:0]   lambda_q;
  logic [DEG_W-1:0]   degree_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [CNT_W-1:0]   acc_q;
  logic [SW-1:0]      root_q [RPC];
  logic               out_valid_q;
  logic               out_first_q;
  logic               out_last_q;
  logic [RPC-1:0]     bitmap_q;
  logic               sum_valid_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic               uncorr_q;

  logic               accept_s;
  logic               advance_s;
  logic [BEAT_W-1:0]  eval_beat_s;
  logic [LAM_W-1:0]   eval_lambda_s;
  logic [SW-1:0]      init_root_s [RPC];
  logic [SW-1:0]      step_root_s [RPC];
  logic [RPC-1:0]     lane_hit_s;
  logic [RPC-1:0]     bitmap_d;
  logic [CNT_W-1:0]   total_s;
  logic               last_d;
  logic               uncorr_d;

  // Count the set lanes in one beat's bitmap.
  function automatic logic [CNT_W-1:0] popcount(input logic [RPC-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int k = 0; k < RPC; k++) begin
      c = c + CNT_W'(v[k]);
    end
    return c;
  endfunction

  assign accept_s  = loc_valid & loc_ready_q;
  assign advance_s = (state_q == ST_SEARCH) & out_valid_q & out_ready;

  // The evaluators always compute the bitmap of the beat that will be
  // presented next. On accept this is beat 0 from the incoming polynomial.
  // On advance it is the following beat from the latched polynomial.
  assign eval_beat_s   = accept_s ? {BEAT_W{1'b0}} : (beat_q + BEAT_W'(1));
  assign eval_lambda_s = accept_s ? error_locator : lambda_q;

  genvar gi;
  generate
    for (gi = 0; gi < RPC; gi++) begin : g_lane
      localparam logic [SW-1:0] INIT_ROOT = gf_alpha_pow((GF_ORDER - (gi % GF_ORDER)) % GF_ORDER);
      localparam logic          IN_LAST   = (gi < LAST_LANES) ? 1'b1 : 1'b0;
      logic [SW-1:0] eval_root_s;
      logic          lane_ok_s;

      assign init_root_s[gi] = INIT_ROOT;
      assign step_root_s[gi] = gf_mul(root_q[gi], STEP_ROOT);
      assign eval_root_s     = accept_s ? INIT_ROOT : step_root_s[gi];
      // Lanes past N_LEN in the final beat never report a root.
      assign lane_ok_s       = (eval_beat_s != LAST_BEAT) | IN_LAST;
      assign lane_hit_s[gi]  = lane_ok_s & (gf_eval(eval_lambda_s, eval_root_s) == {SW{1'b0}});
    end
  endgenerate

  // Map lane i to bitmap bit RPC-1-i, so the lowest position is the MSB.
  always_comb begin
    bitmap_d = {RPC{1'b0}};
    for (int k = 0; k < RPC; k++) begin
      bitmap_d[RPC-1-k] = lane_hit_s[k];
    end
  end

  assign total_s  = acc_q + popcount(bitmap_q);
  assign uncorr_d = (32'(total_s) != 32'(degree_q)) || (32'(degree_q) > 32'(T_LEN));

`ifdef RS_CHIEN_SEQ_EARLY_TERM_EN
  logic [CNT_W-1:0] acc_load_s;
  logic [DEG_W-1:0] eval_deg_s;
  logic             early_s;

  // Flag the beat being loaded as the last beat when the root count
  // accumulated so far already reaches the locator degree.
  always_comb begin
    acc_load_s = accept_s ? {CNT_W{1'b0}} : total_s;
    eval_deg_s = accept_s ? loc_degree : degree_q;
    early_s    = (eval_deg_s != {DEG_W{1'b0}}) &&
                 ((32'(acc_load_s) + 32'(popcount(bitmap_d))) == 32'(eval_deg_s));
    last_d     = (eval_beat_s == LAST_BEAT) | early_s;
  end
`else
  assign last_d = (eval_beat_s == LAST_BEAT);
`endif

  // Main FSM: accept the locator, stream the beats under backpressure, then emit the summary.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      loc_ready_q <= 1'b1;
      lambda_q    <= {LAM_W{1'b0}};
      degree_q    <= {DEG_W{1'b0}};
      beat_q      <= {BEAT_W{1'b0}};
      acc_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      bitmap_q    <= {RPC{1'b0}};
      sum_valid_q <= 1'b0;
      err_cnt_q   <= {CNT_W{1'b0}};
      uncorr_q    <= 1'b0;
      for (int k = 0; k < RPC; k++) begin
        root_q[k] <= {SW{1'b0}};
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q     <= ST_SEARCH;
            loc_ready_q <= 1'b0;
            lambda_q    <= error_locator;
            degree_q    <= loc_degree;
            beat_q      <= {BEAT_W{1'b0}};
            acc_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b1;
            out_first_q <= 1'b1;
            out_last_q  <= last_d;
            bitmap_q    <= bitmap_d;
            for (int k = 0; k < RPC; k++) begin
              root_q[k] <= init_root_s[k];
            end
          end
        end
        ST_SEARCH: begin
          if (advance_s) begin
            if (out_last_q) begin
              state_q     <= ST_SUMMARY;
              out_valid_q <= 1'b0;
              out_first_q <= 1'b0;
              out_last_q  <= 1'b0;
              bitmap_q    <= {RPC{1'b0}};
              sum_valid_q <= 1'b1;
              err_cnt_q   <= total_s;
              uncorr_q    <= uncorr_d;
            end else begin
              beat_q      <= beat_q + BEAT_W'(1);
              acc_q       <= total_s;
              out_first_q <= 1'b0;
              out_last_q  <= last_d;
              bitmap_q    <= bitmap_d;
              for (int k = 0; k < RPC; k++) begin
                root_q[k] <= step_root_s[k];
              end
            end
          end
        end
        ST_SUMMARY: begin
          state_q     <= ST_IDLE;
          sum_valid_q <= 1'b0;
          loc_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          loc_ready_q <= 1'b1;
          out_valid_q <= 1'b0;
          out_first_q <= 1'b0;
          out_last_q  <= 1'b0;
          sum_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign loc_ready     = loc_ready_q;
  assign out_valid     = out_valid_q;
  assign error_bit_pos = bitmap_q;
  assign out_first     = out_first_q;
  assign out_last      = out_last_q;
  assign sum_valid     = sum_valid_q;
  assign err_cnt       = err_cnt_q;
  assign uncorrectable = uncorr_q;

endmodule

// File: tb/tb_rs_chien_seq.sv
// Self-checking bench for rs_chien_seq. It uses random and directed locator
// polynomials and checks them against a brute-force evaluation over all
// positions with log/antilog tables.
module tb_rs_chien_seq;
  import gf_pkg::*;

  localparam int N_LEN = 255;
  localparam int RPC   = 8;
  localparam int BEATS = (N_LEN + RPC - 1) / RPC;
  localparam int LAM_W = (T_LEN + 1) * 8;

  logic             clk;
  logic             rstn;
  logic             loc_valid;
  logic             loc_ready;
  logic [LAM_W-1:0] error_locator;
  logic [3:0]       loc_degree;
  logic             out_valid;
  logic             out_ready;
  logic [RPC-1:0]   error_bit_pos;
  logic             out_first;
  logic             out_last;
  logic             sum_valid;
  logic [7:0]       err_cnt;
  logic             uncorrectable;

  rs_chien_seq #(.N_LEN(N_LEN), .ROOTS_PER_CYCLE(RPC)) dut (
    .clk(clk), .rstn(rstn), .loc_valid(loc_valid), .loc_ready(loc_ready),
    .error_locator(error_locator), .loc_degree(loc_degree),
    .out_valid(out_valid), .out_ready(out_ready), .error_bit_pos(error_bit_pos),
    .out_first(out_first), .out_last(out_last), .sum_valid(sum_valid),
    .err_cnt(err_cnt), .uncorrectable(uncorrectable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_t [0:254];
  int log_t [0:255];
  int lam   [0:T_LEN];
  logic [RPC-1:0] exp_bm [0:BEATS-1];
  int exp_nbeats, exp_cnt, exp_unc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic int gmul(int a, int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  // Lambda(x) = XOR of lam[j] * x^j, with x^j taken from the log tables.
  function automatic int lam_eval(int x);
    int r = 0;
    for (int j = 0; j <= T_LEN; j++)
      if (lam[j] != 0) r ^= exp_t[(log_t[lam[j]] + log_t[x] * j) % 255];
    return r;
  endfunction

  task automatic lam_set_one();
    for (int j = 0; j <= T_LEN; j++) lam[j] = 0;
    lam[0] = 1;
  endtask

  // Multiply Lambda by (1 + alpha^p x), which gives a root at alpha^(-p).
  task automatic add_root(input int p);
    for (int j = T_LEN; j >= 1; j--) lam[j] ^= gmul(exp_t[p % 255], lam[j-1]);
  endtask

  task automatic model(input int deg);
    int cnt;
    for (int b = 0; b < BEATS; b++) exp_bm[b] = '0;
    for (int p = 0; p < N_LEN; p++)
      if (lam_eval(exp_t[(255 - p) % 255]) == 0) exp_bm[p / RPC][RPC - 1 - (p % RPC)] = 1'b1;
    exp_nbeats = BEATS;
    cnt = 0;
    for (int b = 0; b < exp_nbeats; b++) begin
      cnt += $countones(exp_bm[b]);
`ifdef RS_CHIEN_SEQ_EARLY_TERM_EN
      if (deg >= 1 && cnt == deg) exp_nbeats = b + 1;
`endif
    end
    exp_cnt = cnt;
    exp_unc = ((cnt != deg) || (deg > T_LEN)) ? 1 : 0;
  endtask

  // Run one codeword. stall_mode: 0 none, 1 pattern 1,0,0,1, 2 random. abort_beat >= 0 applies reset there.
  task automatic run_cw(input int deg, input int stall_mode, input int abort_beat);
    int guard, b, stalls, k, hs;
    logic rdy;
    model(deg);
    guard = 0;
    while (loc_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val("idle_ready", {31'd0, loc_ready}, 32'd1);
    for (int j = 0; j <= T_LEN; j++) error_locator[j*8 +: 8] = 8'(lam[j]);
    loc_degree = 4'(deg);
    loc_valid  = 1'b1;
    out_ready  = 1'b1;
    @(negedge clk);
    hs = cyc;
    b = 0; stalls = 0; k = 0;
    while (b < exp_nbeats && k < 400) begin
      if (b == abort_beat) begin
        rstn = 1'b0; loc_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        check_val("rst_ready", {31'd0, loc_ready}, 32'd1);
        check_val("rst_outs", {24'd0, error_bit_pos}, 32'd0);
        check_val("rst_flags", {28'd0, out_valid, out_first, out_last, sum_valid}, 32'd0);
        check_val("rst_sum", {23'd0, err_cnt, uncorrectable}, 32'd0);
        @(negedge clk);
        check_val("rst_no_sum", {30'd0, sum_valid, out_valid}, 32'd0);
        return;
      end
      check_val("out_valid", {31'd0, out_valid}, 32'd1);
      check_val("bitmap", {24'd0, error_bit_pos}, {24'd0, exp_bm[b]});
      check_val("first", {31'd0, out_first}, (b == 0) ? 32'd1 : 32'd0);
      check_val("last", {31'd0, out_last}, (b == exp_nbeats - 1) ? 32'd1 : 32'd0);
      check_val("busy", {30'd0, loc_ready, sum_valid}, 32'd0);
      loc_valid = 1'($urandom_range(0, 1));
      for (int j = 0; j <= T_LEN; j++) error_locator[j*8 +: 8] = 8'($urandom);
      case (stall_mode)
        1: rdy = ((k % 4) == 0) || ((k % 4) == 3);
        2: rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      out_ready = rdy;
      @(negedge clk);
      k++;
      if (rdy) b++; else stalls++;
    end
    check_val("beat_budget", {31'd0, (k < 400)}, 32'd1);
    loc_valid = 1'b0;
    out_ready = 1'b1;
    check_val("sum_valid", {31'd0, sum_valid}, 32'd1);
    check_val("err_cnt", {24'd0, err_cnt}, 32'(exp_cnt));
    check_val("uncorr", {31'd0, uncorrectable}, 32'(exp_unc));
    check_val("sum_busy", {30'd0, out_valid, loc_ready}, 32'd0);
    check_val("sum_latency", 32'(cyc - hs), 32'(exp_nbeats + stalls));
    @(negedge clk);
    check_val("sum_pulse", {31'd0, sum_valid}, 32'd0);
    check_val("ready_back", {31'd0, loc_ready}, 32'd1);
    check_val("err_hold", {23'd0, err_cnt, uncorrectable}, 32'((exp_cnt << 1) | exp_unc));
  endtask

  initial begin
    int v, nr, p, deg;
    int used [0:254];
    v = 1;
    for (int k = 0; k < 255; k++) begin
      exp_t[k] = v; log_t[v] = k;
      v = v << 1;
      if (v & 256) v ^= 'h11D;
    end
    log_t[0] = 0;

    rstn = 1'b0; loc_valid = 1'b0; out_ready = 1'b1;
    error_locator = '0; loc_degree = '0;
    repeat (3) @(negedge clk);
    check_val("reset_ready", {31'd0, loc_ready}, 32'd1);
    check_val("reset_outs", {19'd0, error_bit_pos, out_valid, out_first, out_last, sum_valid, uncorrectable}, 32'd0);
    check_val("reset_cnt", {24'd0, err_cnt}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single error at position 3
    lam_set_one(); add_root(3);
    run_cw(1, 0, -1);
    // Roots at 0, 100, 254
    lam_set_one(); add_root(0); add_root(100); add_root(254);
    run_cw(3, 0, -1);
    // 1 + a^5 x + a^9 x^2
    lam_set_one(); lam[1] = exp_t[5]; lam[2] = exp_t[9];
    run_cw(2, 0, -1);
    // Single error with 1,0,0,1 backpressure
    lam_set_one(); add_root(3);
    run_cw(1, 1, -1);
    // Reset mid-search, then Lambda = 1
    lam_set_one(); add_root(3);
    run_cw(1, 0, 10);
    lam_set_one();
    run_cw(0, 0, -1);
    // Degenerate all-zero Lambda
    for (int j = 0; j <= T_LEN; j++) lam[j] = 0;
    run_cw(4, 2, -1);
    // Degree beyond T_LEN
    lam_set_one();
    run_cw(9, 0, -1);

    // Random locators: built from distinct roots, occasionally wrong degree or random coefficients
    for (int it = 0; it < 14; it++) begin
      lam_set_one();
      for (int q = 0; q < 255; q++) used[q] = 0;
      nr = $urandom_range(0, T_LEN);
      for (int r = 0; r < nr; r++) begin
        p = $urandom_range(0, 254);
        while (used[p] != 0) p = (p + 1) % 255;
        used[p] = 1;
        add_root(p);
      end
      deg = nr;
      if ($urandom_range(0, 3) == 0) deg = $urandom_range(0, 15);
      if ($urandom_range(0, 4) == 0)
        for (int j = 0; j <= T_LEN; j++) lam[j] = (j <= deg) ? $urandom_range(0, 255) : 0;
      run_cw(deg, $urandom_range(0, 2), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
